exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle issue/execute sequencer sitting directly upstream of the ALU. It accepts one 16-bit instruction at a time from fetch and decodes it into the ALU's control, immediate and carry/borrow inputs. It owns the architectural carry and borrow flags, sequences LOAD/STOR through a memory handshake, and produces the register-file write-back.

## Interface
- No parameters; data width 16, register index 3 bits, immediate 6 bits.
- clk_pi  in  1  clock; all state updates on rising edge
- rst_n_pi  in  1  asynchronous, active-low reset
- instr_valid_pi / instr_ready_po  in/out  1  fetch handshake; transfer when both high on a clock edge
- instr_pi  in  16  opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3], func[2:0], imm[5:0], ctrl[11:0]
- arith_2op_po, arith_1op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po  out  1  ALU controls
- alu_func_po  out  3  instr[2:0]
- immediate_po  out  6  instr[5:0]
- carry_in_po, borrow_in_po  out  1  current flag values
- reg1_addr_po  out  3  instr[8:6]
- reg2_addr_po  out  3  instr[11:9] for STOR, else instr[5:3]
- reg2_data_pi  in  16  register-file read data for reg2_addr_po (store data)
- alu_result_pi  in  16; carry_out_pi, borrow_out_pi  in  1  ALU outputs
- mem_req_po, mem_we_po  out  1; mem_addr_po, mem_wdata_po  out  16; mem_ack_pi  in  1; mem_rdata_pi  in  16
- reg_we_po  out  1; reg_waddr_po  out  3; reg_wdata_po  out  16  write-back port
- branch_req_po  out  1  one-cycle pulse for BEQ/BGE/BLE/BC/J (resolved by fetch)
- halted_po  out  1  high in HALTED

## Operation
- Opcodes: 0 NOP, 1 ARITH_2OP, 2 ARITH_1OP, 3 MOVI, 4 ADDI, 5 SUBI, 6 LOAD, 7 STOR, 8–C branch/jump, F CONTROL; D/E are treated as NOP.
- CONTROL words: 0x001 STC, 0x002 STB, 0xAAA soft RESET, 0xFFF HALT. Any other CONTROL word is a NOP.
- States: IDLE, EXEC, MEM, WB, HALTED. Instruction register IR loads on accept.
- IDLE: instr_ready_po=1. On accept go to EXEC.
- EXEC:
  - Drives ALU controls decoded from IR. All ALU controls are 0 in every other state.
  - Captures alu_result_pi into result register RES.
  - Loads carry/borrow flags from carry_out_pi/borrow_out_pi for every opcode except soft RESET (the ALU propagates flags when not generating them).
  - Next state: LOAD/STOR go to MEM; ARITH_2OP/ARITH_1OP/ADDI/SUBI/MOVI go to WB.
  - NOP, branch, STC, STB and invalid opcodes go to IDLE; branch also pulses branch_req_po.
  - HALT goes to HALTED.
  - Soft RESET clears both flags and returns to IDLE.
- MEM:
  - mem_req_po=1 held until mem_ack_pi; mem_addr_po=RES.
  - STOR: mem_we_po=1, mem_wdata_po=reg2_data_pi; on ack go to IDLE.
  - LOAD: mem_we_po=0; on ack capture mem_rdata_pi into RES and go to WB.
- WB: reg_we_po=1 for exactly one cycle, reg_waddr_po=IR[11:9], then IDLE.
  - reg_wdata_po = RES, except MOVI, which writes sign-extended IR[5:0].
- HALTED: instr_ready_po=0, halted_po=1; exits only on rst_n_pi.
- Flag width rule: flags are single bits; sign extension is {10{imm[5]}, imm}.

## Timing
- Reset (asynchronous, any state including mid-MEM):
  - State IDLE; IR, RES and flags cleared.
  - All outputs 0 except instr_ready_po=1.
  - mem_req_po drops immediately; a late mem_ack_pi after reset is ignored.
- Latency from accept edge:
  - ALU op/MOVI: EXEC cycle 1, WB cycle 2, ready again cycle 3.
  - NOP/STC/STB/branch: ready at cycle 2.
  - LOAD with ack after k MEM cycles (k≥1): write-back at cycle 2+k.
- mem_ack_pi is sampled only in MEM; an ack seen in the same cycle as the request completes it.
- Throughput: one instruction in flight; instr_ready_po is low in every state except IDLE.
- instr_valid_pi held low in IDLE: remain in IDLE, no outputs toggle.

## Test plan
- Reset, then ADD r1=0xFFFF + r2=0x0001 (ALU returns 0x0000, carry_out=1) → reg_we at cycle 2 with wdata 0x0000, waddr=rd; carry_in_po=1 afterwards.
- MOVI rd=3, imm=6'b100000 → reg_wdata_po=0xFFE0, waddr 3, ALU controls all 0 throughout.
- LOAD with mem_ack_pi delayed 3 cycles, ALU address 0x0040, rdata 0x1234 → mem_req_po high 3 cycles at addr 0x0040, write 0x1234 at cycle 5.
- STOR → mem_we_po=1, mem_wdata_po=reg2_data_pi, no reg_we_po, back to IDLE after ack.
- STC, then soft RESET → carry_in_po=1 after STC, 0 after RESET; HALT → halted_po=1, instr_ready_po=0 until rst_n_pi.
- Assert rst_n_pi low during MEM wait → mem_req_po and all outputs drop immediately, instr_ready_po=1, flags 0.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: issue/execute FSM decoding 16-bit instructions into ALU controls, owning carry/borrow flags, LOAD/STOR memory handshake and register write-back
module exec_sequencer (
  input  logic        clk_pi,
  input  logic        rst_n_pi,
  input  logic        instr_valid_pi,
  output logic        instr_ready_po,
  input  logic [15:0] instr_pi,
  output logic        arith_2op_po,
  output logic        arith_1op_po,
  output logic        addi_po,
  output logic        subi_po,
  output logic        load_or_store_po,
  output logic        stc_cmd_po,
  output logic        stb_cmd_po,
  output logic [2:0]  alu_func_po,
  output logic [5:0]  immediate_po,
  output logic        carry_in_po,
  output logic        borrow_in_po,
  output logic [2:0]  reg1_addr_po,
  output logic [2:0]  reg2_addr_po,
  input  logic [15:0] reg2_data_pi,
  input  logic [15:0] alu_result_pi,
  input  logic        carry_out_pi,
  input  logic        borrow_out_pi,
  output logic        mem_req_po,
  output logic        mem_we_po,
  output logic [15:0] mem_addr_po,
  output logic [15:0] mem_wdata_po,
  input  logic        mem_ack_pi,
  input  logic [15:0] mem_rdata_pi,
  output logic        reg_we_po,
  output logic [2:0]  reg_waddr_po,
  output logic [15:0] reg_wdata_po,
  output logic        branch_req_po,
  output logic        halted_po
);
  typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, HALTED} state_t;
  state_t state_q, state_d;
  logic [15:0] ir_q, ir_d, res_q, res_d;
  logic carry_q, carry_d, borrow_q, borrow_d;
  logic [3:0] op;
  logic is_load, is_stor, is_movi, is_ctl, soft_rst, halt, to_wb;
  logic in_exec, in_mem, in_wb;
  assign op       = ir_q[15:12];
  assign is_load  = op == 4'h6;
  assign is_stor  = op == 4'h7;
  assign is_movi  = op == 4'h3;
  assign is_ctl   = op == 4'hF;
  assign soft_rst = is_ctl && ir_q[11:0] == 12'hAAA;
  assign halt     = is_ctl && ir_q[11:0] == 12'hFFF;
  assign to_wb    = op == 4'h1 || op == 4'h2 || op == 4'h3 || op == 4'h4 || op == 4'h5;
  assign in_exec  = state_q == EXEC;
  assign in_mem   = state_q == MEM;
  assign in_wb    = state_q == WB;
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    res_d    = res_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: if (instr_valid_pi) begin
        ir_d    = instr_pi;
        state_d = EXEC;
      end
      EXEC: begin
        res_d    = alu_result_pi;
        carry_d  = soft_rst ? 1'b0 : carry_out_pi;
        borrow_d = soft_rst ? 1'b0 : borrow_out_pi;
        state_d  = halt ? HALTED : (is_load || is_stor) ? MEM : to_wb ? WB : IDLE;
      end
      MEM: if (mem_ack_pi) begin
        res_d   = is_load ? mem_rdata_pi : res_q;
        state_d = is_load ? WB : IDLE;
      end
      WB: state_d = IDLE;
      default: state_d = HALTED;
    endcase
  end
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end
  assign instr_ready_po   = state_q == IDLE;
  assign arith_2op_po     = in_exec && op == 4'h1;
  assign arith_1op_po     = in_exec && op == 4'h2;
  assign addi_po          = in_exec && op == 4'h4;
  assign subi_po          = in_exec && op == 4'h5;
  assign load_or_store_po = in_exec && (is_load || is_stor);
  assign stc_cmd_po       = in_exec && is_ctl && ir_q[11:0] == 12'h001;
  assign stb_cmd_po       = in_exec && is_ctl && ir_q[11:0] == 12'h002;
  assign alu_func_po      = ir_q[2:0];
  assign immediate_po     = ir_q[5:0];
  assign carry_in_po      = carry_q;
  assign borrow_in_po     = borrow_q;
  assign reg1_addr_po     = ir_q[8:6];
  assign reg2_addr_po     = is_stor ? ir_q[11:9] : ir_q[5:3];
  assign mem_req_po       = in_mem;
  assign mem_we_po        = in_mem && is_stor;
  assign mem_addr_po      = in_mem ? res_q : '0;
  assign mem_wdata_po     = mem_we_po ? reg2_data_pi : '0;
  assign reg_we_po        = in_wb;
  assign reg_waddr_po     = in_wb ? ir_q[11:9] : '0;
  assign reg_wdata_po     = in_wb ? (is_movi ? {{10{ir_q[5]}}, ir_q[5:0]} : res_q) : '0;
  assign branch_req_po    = in_exec && op >= 4'h8 && op <= 4'hC;
  assign halted_po        = state_q == HALTED;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed scoreboard bench for exec_sequencer
module tb_exec_sequencer;
  logic clk = 0, rst_n = 0;
  logic instr_valid = 0;
  logic [15:0] instr = 0, reg2_data = 0, alu_result = 0, mem_rdata = 0;
  logic carry_out = 0, borrow_out = 0, mem_ack = 0;
  logic instr_ready, arith_2op, arith_1op, addi, subi, ls, stc, stb;
  logic [2:0] alu_func, reg1_addr, reg2_addr, reg_waddr;
  logic [5:0] imm;
  logic carry_in, borrow_in, mem_req, mem_we, reg_we, branch_req, halted;
  logic [15:0] mem_addr, mem_wdata, reg_wdata;
  int n_chk = 0, n_pass = 0;
  logic [18:0] wbq[$];
  logic [31:0] stq[$];
  logic [18:0] wb_exp;
  logic [31:0] st_exp;
  logic [6:0] ctrls;
  logic [79:0] outs;
  always #5 clk = ~clk;
  exec_sequencer dut (
    .clk_pi(clk), .rst_n_pi(rst_n), .instr_valid_pi(instr_valid), .instr_ready_po(instr_ready),
    .instr_pi(instr), .arith_2op_po(arith_2op), .arith_1op_po(arith_1op), .addi_po(addi),
    .subi_po(subi), .load_or_store_po(ls), .stc_cmd_po(stc), .stb_cmd_po(stb),
    .alu_func_po(alu_func), .immediate_po(imm), .carry_in_po(carry_in), .borrow_in_po(borrow_in),
    .reg1_addr_po(reg1_addr), .reg2_addr_po(reg2_addr), .reg2_data_pi(reg2_data),
    .alu_result_pi(alu_result), .carry_out_pi(carry_out), .borrow_out_pi(borrow_out),
    .mem_req_po(mem_req), .mem_we_po(mem_we), .mem_addr_po(mem_addr), .mem_wdata_po(mem_wdata),
    .mem_ack_pi(mem_ack), .mem_rdata_pi(mem_rdata), .reg_we_po(reg_we), .reg_waddr_po(reg_waddr),
    .reg_wdata_po(reg_wdata), .branch_req_po(branch_req), .halted_po(halted)
  );
  assign ctrls = {arith_2op, arith_1op, addi, subi, ls, stc, stb};
  assign outs = {ctrls, alu_func, imm, carry_in, borrow_in, reg1_addr, reg2_addr, mem_req, mem_we,
                 mem_addr, mem_wdata, reg_we, reg_waddr, reg_wdata, branch_req, halted};
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] x);
    chk("ready_before_issue", instr_ready, 1'b1);
    instr_valid = 1;
    instr = x;
    @(posedge clk);
    #1 instr_valid = 0;
  endtask
  always @(negedge clk) begin
    if (reg_we) begin
      n_chk++;
      assert (wbq.size() > 0) n_pass++;
      else $error("FAIL wb_unexpected observed=%0h expected=none", {reg_waddr, reg_wdata});
      if (wbq.size() > 0) begin
        wb_exp = wbq.pop_front();
        chk("wb_port", {reg_waddr, reg_wdata}, wb_exp);
      end
    end
    if (mem_req && mem_we && mem_ack) begin
      n_chk++;
      assert (stq.size() > 0) n_pass++;
      else $error("FAIL st_unexpected observed=%0h expected=none", {mem_addr, mem_wdata});
      if (stq.size() > 0) begin
        st_exp = stq.pop_front();
        chk("st_port", {mem_addr, mem_wdata}, st_exp);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_outs", outs, 80'h0);
    chk("rst_ready", instr_ready, 1'b1);
    step(1);
    rst_n = 1;
    step(2);
    chk("idle_outs", outs, 80'h0);
    chk("idle_ready", instr_ready, 1'b1);
    alu_result = 16'h0000; carry_out = 1; borrow_out = 0;
    wbq.push_back({3'd5, 16'h0000});
    issue({4'h1, 3'd5, 3'd1, 3'd2, 3'd0});
    chk("add_ctrl", ctrls, 7'b1000000);
    chk("add_ready", instr_ready, 1'b0);
    chk("add_regs", {reg1_addr, reg2_addr}, {3'd1, 3'd2});
    step(1);
    chk("add_we", reg_we, 1'b1);
    chk("add_carry", carry_in, 1'b1);
    chk("add_wb_ctrl", ctrls, 7'b0);
    step(1);
    chk("add_ready_c3", instr_ready, 1'b1);
    chk("add_we_off", reg_we, 1'b0);
    alu_result = 16'h5555;
    wbq.push_back({3'd3, 16'hFFE0});
    issue({4'h3, 3'd3, 3'd0, 6'b100000});
    chk("movi_ctrl", ctrls, 7'b0);
    step(1);
    chk("movi_wb", {reg_we, reg_waddr, reg_wdata}, {1'b1, 3'd3, 16'hFFE0});
    chk("movi_wb_ctrl", ctrls, 7'b0);
    step(1);
    alu_result = 16'h0040; carry_out = 0; borrow_out = 1; mem_rdata = 16'h1234;
    wbq.push_back({3'd2, 16'h1234});
    issue({4'h6, 3'd2, 3'd4, 6'd0});
    chk("load_ctrl", ctrls, 7'b0000100);
    chk("load_noreq_exec", mem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("load_req", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0040});
      if (i == 2) mem_ack = 1;
    end
    step(1);
    mem_ack = 0;
    chk("load_wb_c5", {reg_we, reg_wdata, mem_req}, {1'b1, 16'h1234, 1'b0});
    chk("load_flags", {carry_in, borrow_in}, 2'b01);
    step(1);
    alu_result = 16'h0100; reg2_data = 16'hBEEF;
    stq.push_back({16'h0100, 16'hBEEF});
    issue({4'h7, 3'd6, 3'd1, 3'd0, 3'd0});
    chk("stor_reg2", reg2_addr, 3'd6);
    step(1);
    chk("stor_mem", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0100, 16'hBEEF});
    mem_ack = 1;
    step(1);
    mem_ack = 0;
    chk("stor_idle", {instr_ready, reg_we, mem_req}, 3'b100);
    issue({4'h9, 12'h000});
    chk("br_pulse", branch_req, 1'b1);
    step(1);
    chk("br_done", {branch_req, instr_ready}, 2'b01);
    chk("pre_stc_carry", carry_in, 1'b0);
    carry_out = 1;
    issue({4'hF, 12'h001});
    chk("stc_ctrl", ctrls, 7'b0000010);
    step(1);
    chk("stc_carry", {carry_in, instr_ready}, 2'b11);
    borrow_out = 1;
    issue({4'hF, 12'hAAA});
    step(1);
    chk("srst_flags", {carry_in, borrow_in, instr_ready}, 3'b001);
    alu_result = 16'h0080;
    issue({4'h6, 3'd1, 3'd0, 6'd0});
    step(1);
    chk("mid_mem_req", mem_req, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_outs", outs, 80'h0);
    chk("mid_rst_ready", instr_ready, 1'b1);
    mem_ack = 1;
    #3 rst_n = 1;
    step(1);
    chk("late_ack", {instr_ready, reg_we, mem_req}, 3'b100);
    mem_ack = 0;
    issue({4'hF, 12'hFFF});
    step(1);
    chk("halt", {halted, instr_ready}, 2'b10);
    instr_valid = 1;
    instr = {4'h1, 12'h0};
    step(3);
    chk("halt_stays", {halted, instr_ready, ctrls}, {2'b10, 7'b0});
    instr_valid = 0;
    rst_n = 0;
    #1;
    chk("halt_rst", {halted, instr_ready}, 2'b01);
    #2 rst_n = 1;
    step(1);
    chk("wbq_empty", wbq.size(), 0);
    chk("stq_empty", stq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
